// File: rtl/control_pipeline.sv
// Control-bundle pipeline: ID/EX, EX/MEM, MEM/WB registers,
// EX-stage branch/jump resolution and retired-instruction counter.
module control_pipeline #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                d_result_src,
   input  logic                      d_mem_write,
   input  logic                      d_alu_src,
   input  logic                      d_reg_write,
   input  logic                      d_branch,
   input  logic                      d_jump,
   input  logic [REG_ADDR_WIDTH-1:0] d_rd,
   input  logic                      d_valid,
   input  logic                      id_ex_bubble,
   input  logic                      e_zero,
   output logic                      e_alu_src,
   output logic                      e_reg_write,
   output logic [1:0]                e_result_src,
   output logic [REG_ADDR_WIDTH-1:0] e_rd,
   output logic                      pc_src_e,
   output logic                      flush_d,
   output logic                      m_mem_write,
   output logic                      m_reg_write,
   output logic [1:0]                m_result_src,
   output logic [REG_ADDR_WIDTH-1:0] m_rd,
   output logic                      w_reg_write,
   output logic [1:0]                w_result_src,
   output logic [REG_ADDR_WIDTH-1:0] w_rd,
   output logic                      w_valid,
   output logic [CNT_WIDTH-1:0]      instret
);

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic [1:0]                result_src;
      logic                      mem_write;
      logic                      alu_src;
      logic                      branch;
      logic                      jump;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } ex_t;

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic [1:0]                result_src;
      logic                      mem_write;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } mem_t;

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic [1:0]                result_src;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } wb_t;

   ex_t                  r_ex;
   mem_t                 r_mem;
   wb_t                  r_wb;
   logic [CNT_WIDTH-1:0] r_instret;
   ex_t                  w_dec;
   logic                 w_take;

   always_comb begin
      w_dec            = '0;
      w_dec.valid      = d_valid;
      w_dec.reg_write  = d_reg_write;
      w_dec.result_src = d_result_src;
      w_dec.mem_write  = d_mem_write;
      w_dec.alu_src    = d_alu_src;
      w_dec.branch     = d_branch;
      w_dec.jump       = d_jump;
      w_dec.rd         = d_rd;
   end

   // An empty EX slot has branch=jump=0, so bubbles never redirect.
   assign w_take = r_ex.jump | (r_ex.branch & e_zero);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex      <= '0;
         r_mem     <= '0;
         r_wb      <= '0;
         r_instret <= '0;
      end else begin
         r_ex             <= (w_take | id_ex_bubble) ? '0 : w_dec;
         r_mem.valid      <= r_ex.valid;
         r_mem.reg_write  <= r_ex.reg_write;
         r_mem.result_src <= r_ex.result_src;
         r_mem.mem_write  <= r_ex.mem_write;
         r_mem.rd         <= r_ex.rd;
         r_wb.valid       <= r_mem.valid;
         r_wb.reg_write   <= r_mem.reg_write;
         r_wb.result_src  <= r_mem.result_src;
         r_wb.rd          <= r_mem.rd;
         if (r_wb.valid)
            r_instret <= r_instret + CNT_WIDTH'(1);
      end
   end

   assign e_alu_src    = r_ex.alu_src;
   assign e_reg_write  = r_ex.reg_write;
   assign e_result_src = r_ex.result_src;
   assign e_rd         = r_ex.rd;
   assign pc_src_e     = w_take;
   assign flush_d      = w_take;
   assign m_mem_write  = r_mem.mem_write;
   assign m_reg_write  = r_mem.reg_write;
   assign m_result_src = r_mem.result_src;
   assign m_rd         = r_mem.rd;
   assign w_reg_write  = r_wb.reg_write;
   assign w_result_src = r_wb.result_src;
   assign w_rd         = r_wb.rd;
   assign w_valid      = r_wb.valid;
   assign instret      = r_instret;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: slot-history model checked
// every cycle, plus hand-computed literal expectations.
module tb_control_pipeline;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    d_result_src;
   logic          d_mem_write, d_alu_src, d_reg_write;
   logic          d_branch, d_jump, d_valid;
   logic [4:0]    d_rd;
   logic          id_ex_bubble, e_zero;
   logic          e_alu_src, e_reg_write, pc_src_e, flush_d;
   logic [1:0]    e_result_src, m_result_src, w_result_src;
   logic [4:0]    e_rd, m_rd, w_rd;
   logic          m_mem_write, m_reg_write, w_reg_write, w_valid;
   logic [CW-1:0] instret;

   control_pipeline #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .d_result_src(d_result_src), .d_mem_write(d_mem_write),
      .d_alu_src(d_alu_src), .d_reg_write(d_reg_write),
      .d_branch(d_branch), .d_jump(d_jump), .d_rd(d_rd),
      .d_valid(d_valid), .id_ex_bubble(id_ex_bubble), .e_zero(e_zero),
      .e_alu_src(e_alu_src), .e_reg_write(e_reg_write),
      .e_result_src(e_result_src), .e_rd(e_rd),
      .pc_src_e(pc_src_e), .flush_d(flush_d),
      .m_mem_write(m_mem_write), .m_reg_write(m_reg_write),
      .m_result_src(m_result_src), .m_rd(m_rd),
      .w_reg_write(w_reg_write), .w_result_src(w_result_src),
      .w_rd(w_rd), .w_valid(w_valid), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v, rw, mw, as, br, jp;
      bit [1:0] rs;
      bit [4:0] rd;
   } slot_t;

   // hist[0] is in EX, hist[1] in MEM, hist[2] in WB
   slot_t hist[$];
   int    retired = 0;
   int    n_chk = 0;
   int    n_pass = 0;
   bit    en = 0;

   function automatic slot_t at(int i);
      slot_t b;
      b = '{default: 0};
      if (i < hist.size()) return hist[i];
      return b;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   task automatic model_step();
      slot_t e, nx;
      if (rst) begin
         hist.delete();
         retired = 0;
         return;
      end
      if (at(2).v) retired++;
      e  = at(0);
      nx = '{default: 0};
      if (!(e.jp || (e.br && e_zero)) && !id_ex_bubble) begin
         nx.v  = d_valid;  nx.rw = d_reg_write;
         nx.mw = d_mem_write; nx.as = d_alu_src;
         nx.br = d_branch; nx.jp = d_jump;
         nx.rs = d_result_src; nx.rd = d_rd;
      end
      hist.push_front(nx);
      if (hist.size() > 3) void'(hist.pop_back());
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drv(bit v, bit rw, bit [1:0] rs, bit br, bit jp,
                      bit [4:0] rd, bit bub, bit z);
      d_valid = v; d_reg_write = rw; d_result_src = rs;
      d_mem_write = (rs == 2'b00) && v && !rw;
      d_alu_src = v; d_branch = br; d_jump = jp; d_rd = rd;
      id_ex_bubble = bub; e_zero = z;
   endtask

   task automatic nop();
      drv(0, 0, 2'b00, 0, 0, 5'd0, 0, 0);
   endtask

   always @(negedge clk) begin
      slot_t e, m, w;
      if (en) begin
         e = at(0); m = at(1); w = at(2);
         chk("e_alu_src", 32'(e_alu_src), 32'(e.as));
         chk("e_reg_write", 32'(e_reg_write), 32'(e.rw));
         chk("e_result_src", 32'(e_result_src), 32'(e.rs));
         chk("e_rd", 32'(e_rd), 32'(e.rd));
         chk("pc_src_e", 32'(pc_src_e), 32'(e.jp | (e.br & e_zero)));
         chk("flush_d", 32'(flush_d), 32'(e.jp | (e.br & e_zero)));
         chk("m_mem_write", 32'(m_mem_write), 32'(m.mw));
         chk("m_reg_write", 32'(m_reg_write), 32'(m.rw));
         chk("m_result_src", 32'(m_result_src), 32'(m.rs));
         chk("m_rd", 32'(m_rd), 32'(m.rd));
         chk("w_reg_write", 32'(w_reg_write), 32'(w.rw));
         chk("w_result_src", 32'(w_result_src), 32'(w.rs));
         chk("w_rd", 32'(w_rd), 32'(w.rd));
         chk("w_valid", 32'(w_valid), 32'(w.v));
         chk("instret", 32'(instret), 32'(retired % (1 << CW)));
      end
   end

   initial begin
      rst = 1'b1;
      drv(1, 1, 2'b01, 1, 1, 5'd7, 1, 1);
      tick();
      tick();
      en = 1;
      chk("rst_w_valid", 32'(w_valid), 32'd0);
      chk("rst_e_rd", 32'(e_rd), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      rst = 1'b0;
      nop();
      tick();
      chk("post_rst_m_rd", 32'(m_rd), 32'd0);

      // four back-to-back adds, rd=1..4
      for (int k = 1; k <= 7; k++) begin
         if (k <= 4) drv(1, 1, 2'b00, 0, 0, 5'(k), 0, 0);
         else nop();
         tick();
         if (k >= 3 && k <= 6) chk("stream_w_rd", 32'(w_rd), 32'(k - 2));
      end
      chk("stream_instret", 32'(instret), 32'd4);

      // load-use
      drv(1, 1, 2'b01, 0, 0, 5'd5, 0, 0);
      tick();
      drv(1, 1, 2'b00, 0, 0, 5'd6, 1, 0);
      tick();
      chk("lu_e_reg_write", 32'(e_reg_write), 32'd0);
      chk("lu_e_rd", 32'(e_rd), 32'd0);
      drv(1, 1, 2'b00, 0, 0, 5'd6, 0, 0);
      tick();
      chk("lu_held_e_rd", 32'(e_rd), 32'd6);
      chk("lu_load_w_rd", 32'(w_rd), 32'd5);
      nop();
      tick();
      chk("lu_bubble_w_valid", 32'(w_valid), 32'd0);

      // taken branch
      drv(1, 0, 2'b00, 1, 0, 5'd0, 0, 0);
      tick();
      drv(1, 1, 2'b00, 0, 0, 5'd9, 0, 1);
      #1;
      chk("br_pc_src", 32'(pc_src_e), 32'd1);
      chk("br_flush_d", 32'(flush_d), 32'd1);
      tick();
      chk("br_sq_e_rw", 32'(e_reg_write), 32'd0);
      nop();
      tick();
      chk("br_retires_w_valid", 32'(w_valid), 32'd1);

      // not-taken branch
      drv(1, 0, 2'b00, 1, 0, 5'd0, 0, 0);
      tick();
      drv(1, 1, 2'b00, 0, 0, 5'd10, 0, 0);
      #1;
      chk("nt_pc_src", 32'(pc_src_e), 32'd0);
      tick();
      chk("nt_e_rd", 32'(e_rd), 32'd10);

      // jump with simultaneous load-use bubble
      drv(1, 1, 2'b10, 0, 1, 5'd1, 0, 0);
      tick();
      drv(1, 1, 2'b00, 0, 0, 5'd11, 1, 0);
      #1;
      chk("jmp_pc_src", 32'(pc_src_e), 32'd1);
      tick();
      chk("jmp_bub_e_rd", 32'(e_rd), 32'd0);
      drv(1, 1, 2'b00, 0, 0, 5'd11, 0, 0);
      tick();
      chk("jmp_held_e_rd", 32'(e_rd), 32'd11);
      chk("jmp_w_reg_write", 32'(w_reg_write), 32'd1);
      chk("jmp_w_rd", 32'(w_rd), 32'd1);

      // counter wrap
      nop();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wrap_rst_instret", 32'(instret), 32'd0);
      for (int k = 1; k <= 18; k++) begin
         if (k <= 15) drv(1, 1, 2'b00, 0, 0, 5'(k), 0, 0);
         else nop();
         tick();
      end
      chk("wrap_15", 32'(instret), 32'd15);
      drv(1, 1, 2'b00, 0, 0, 5'd3, 0, 0);
      tick();
      nop();
      tick(); tick(); tick();
      chk("wrap_0", 32'(instret), 32'd0);

      // mid-run reset with instructions in flight
      for (int k = 1; k <= 4; k++) begin
         drv(1, 1, 2'b00, 0, 0, 5'(k + 20), 0, 0);
         tick();
      end
      chk("mid_pre_instret", 32'(instret), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nop();
      chk("mid_rst_instret", 32'(instret), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_w_valid", 32'(w_valid), 32'd0);
      end
      chk("mid_end_instret", 32'(instret), 32'd0);

      @(negedge clk);
      en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
